// File: rtl/display_scan_mux_pkg.sv
// rtl/display_scan_mux_pkg.sv - shared 7-segment encodings and anode constants
package display_scan_mux_pkg;

    localparam int MAX_DIGITS = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex nibble to active-low 7-segment decoder
module seg7_decoder
    import display_scan_mux_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_OFF;
        case (nibble)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
            default: segments = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed 7-segment scanner with dead time and blanking
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500,
    parameter int IDX_W           = $clog2(NUM_DIGITS)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   anodo,
    output logic [6:0]              segmentos,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_pulse
);

    localparam int                    CNT_W       = $clog2(TICKS_PER_DIGIT);
    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK   = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_IDLE  = ANODES_OFF[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            lat_nib;
    logic                  lat_dp;
    logic                  lat_blank;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic                  lit;
    logic                  slot_start;

    assign slot_start = enable && (cnt == '0);

    // Prescaler, digit index and per-slot latch all freeze while enable is low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            idx       <= '0;
            lat_nib   <= 4'h0;
            lat_dp    <= 1'b0;
            lat_blank <= 1'b1;
        end else if (enable) begin
            if (cnt == '0) begin
                lat_nib   <= digits_in[4*idx +: 4];
                lat_dp    <= dp_in[idx];
                lat_blank <= blank_mask[idx];
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    seg7_decoder u_dec (
        .nibble   (lat_nib),
        .segments (dec_seg)
    );

    always_comb begin
        anode_sel = ANODE_IDLE;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_sel[k] = (idx != IDX_W'(k));
        end
    end

    // Dead time covers the latch cycle, so the previous digit's data never leaks
    assign lit = enable && (cnt >= CNT_BLANK) && !lat_blank;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anodo       <= ANODE_IDLE;
            segmentos   <= SEG_OFF;
            dp          <= 1'b1;
            digit_idx   <= '0;
            frame_pulse <= 1'b0;
        end else begin
            anodo       <= lit ? anode_sel : ANODE_IDLE;
            segmentos   <= lit ? dec_seg : SEG_OFF;
            dp          <= lit ? ~lat_dp : 1'b1;
            digit_idx   <= idx;
            frame_pulse <= slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - randomized self-checking bench for display_scan_mux
module tb_display_scan_mux;

    localparam int T = 8;
    localparam int B = 2;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic [3:0]  anodo;
    logic [6:0]  segmentos;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_pulse;

    logic        rst3_n;
    logic        en3;
    logic [11:0] digits3;
    logic [2:0]  dp3_in;
    logic [2:0]  blank3;
    logic [2:0]  anodo3;
    logic [6:0]  seg3;
    logic        dp3;
    logic [1:0]  idx3;
    logic        fp3;

    always #5 clock = ~clock;

    display_scan_mux #(.NUM_DIGITS(4), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .blank_mask(blank_mask), .anodo(anodo), .segmentos(segmentos),
        .dp(dp), .digit_idx(digit_idx), .frame_pulse(frame_pulse)
    );

    display_scan_mux #(.NUM_DIGITS(3), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut3 (
        .clock(clock), .reset_n(rst3_n), .enable(en3), .digits_in(digits3),
        .dp_in(dp3_in), .blank_mask(blank3), .anodo(anodo3), .segmentos(seg3),
        .dp(dp3), .digit_idx(idx3), .frame_pulse(fp3)
    );

    logic [6:0]  seg_ref [16];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: position within the frame counted in enabled cycles
    int          pos;
    logic [3:0]  m_nib;
    logic        m_dp;
    logic        m_blank;
    logic [14:0] exp_v;
    logic [14:0] obs_v;

    task automatic model_reset();
        pos = 0; m_nib = 4'h0; m_dp = 1'b0; m_blank = 1'b1;
    endtask

    task automatic step();
        int  off;
        int  slot;
        logic lit;
        logic fr;
        off  = pos % T;
        slot = (pos / T) % N;
        if (enable && off == 0) begin
            m_nib   = digits_in[4*slot +: 4];
            m_dp    = dp_in[slot];
            m_blank = blank_mask[slot];
        end
        lit = enable && (off >= B) && !m_blank;
        fr  = enable && (pos == 0);
        if (lit) exp_v = {~(4'b0001 << slot), seg_ref[m_nib], ~m_dp, 2'(slot), fr};
        else     exp_v = {4'hF, 7'h7F, 1'b1, 2'(slot), fr};
        if (enable) pos = (pos + 1) % (T * N);
        @(posedge clock);
        #1;
        obs_v = {anodo, segmentos, dp, digit_idx, frame_pulse};
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1; digits_in = 16'h4321; dp_in = 4'h0; blank_mask = 4'h0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({anodo, segmentos, dp, digit_idx, frame_pulse} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h",
                     {anodo, segmentos, dp, digit_idx, frame_pulse}, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_scan();
        int frames = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            frames += frame_pulse;
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL scan cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
        n_cmp++;
        if (frames != 2) begin
            n_err++;
            $display("FAIL scan_frame_count: got %0d expected 2", frames);
        end
    endtask

    task automatic test_blanking();
        int lit2 = 0;
        blank_mask = 4'b0100;
        for (int i = 0; i < 64; i++) begin
            step();
            if (digit_idx == 2'd2 && (anodo !== 4'hF || segmentos !== 7'h7F)) lit2++;
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL blanking cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
        n_cmp++;
        if (lit2 != 0) begin
            n_err++;
            $display("FAIL blanked_slot_lit_cycles: got %0d expected 0", lit2);
        end
        blank_mask = 4'h0;
    endtask

    task automatic test_mid_slot();
        int bad = 0;
        digits_in = 16'h0000;
        for (int g = 0; g < 64 && pos != T + 4; g++) begin
            step();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL mid_slot_pre: got %h expected %h", obs_v, exp_v);
            end
        end
        digits_in = 16'h8888;
        for (int i = 0; i < 28; i++) begin
            step();
            if (anodo == 4'b1101 && segmentos !== 7'h40) bad++;
            if (anodo == 4'b1011 && segmentos !== 7'h00) bad++;
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL mid_slot cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL mid_slot_segments: got %0d wrong cycles expected 0", bad);
        end
    endtask

    task automatic test_enable_hold();
        digits_in = 16'h9A5C; dp_in = 4'b1010;
        for (int g = 0; g < 64 && pos != 3 * T + 5; g++) begin
            step();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL hold_pre: got %h expected %h", obs_v, exp_v);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (obs_v !== exp_v || digit_idx !== 2'd3 || anodo !== 4'hF) begin
                n_err++;
                $display("FAIL hold cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL hold_resume cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int g = 0; g < 64 && pos != 2 * T + 4; g++) begin
            step();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL areset_pre: got %h expected %h", obs_v, exp_v);
            end
        end
        #2;
        n_cmp++;
        if (anodo !== 4'b1011) begin
            n_err++;
            $display("FAIL areset_lit_before: got %b expected 1011", anodo);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (anodo !== 4'hF || segmentos !== 7'h7F || dp !== 1'b1 || digit_idx !== 2'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got %b %h %b %0d expected 1111 7f 1 0",
                     anodo, segmentos, dp, digit_idx);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL areset_restart cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 5) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 5) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom) & 4'($urandom);
            step();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs_v, exp_v);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_three_digits();
        logic [13:0] e3;
        int          frames = 0;
        int          off;
        int          slot;
        digits3 = 12'($urandom);
        @(negedge clock);
        rst3_n = 1'b1;
        for (int t = 0; t < 72; t++) begin
            off  = t % T;
            slot = (t / T) % 3;
            if (off >= B)
                e3 = {~(3'b001 << slot), seg_ref[digits3[4*slot +: 4]], 1'b1, 2'(slot), 1'(t % 24 == 0)};
            else
                e3 = {3'b111, 7'h7F, 1'b1, 2'(slot), 1'(t % 24 == 0)};
            @(posedge clock);
            #1;
            frames += fp3;
            n_cmp++;
            if ({anodo3, seg3, dp3, idx3, fp3} !== e3) begin
                n_err++;
                $display("FAIL three_digit cycle %0d: got %h expected %h", t, {anodo3, seg3, dp3, idx3, fp3}, e3);
            end
        end
        n_cmp++;
        if (frames != 3) begin
            n_err++;
            $display("FAIL three_digit_frames: got %0d expected 3", frames);
        end
    endtask

    initial begin
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst3_n = 1'b0; en3 = 1'b1; digits3 = 12'h0; dp3_in = 3'b000; blank3 = 3'b000;
        reset_n = 1'b0; enable = 1'b1; digits_in = 16'h0; dp_in = 4'h0; blank_mask = 4'h0;
        test_reset();
        test_scan();
        test_blanking();
        test_mid_slot();
        test_enable_hold();
        test_async_reset();
        apply_reset();
        test_random();
        test_three_digits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
Parametrised time-multiplexed 7-segment display scanner for the scoreboard. It replaces external 60/120 Hz select clocks with an internal prescaler and a digit-index counter. It scans NUM_DIGITS digits, latching each digit's nibble at slot start and decoding it to segments. Features beyond the current mux: per-digit blanking, inter-digit dead time (anti-ghosting), an enable/hold input and a frame-start pulse. It sits between the score/timer BCD registers and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 2..8
TICKS_PER_DIGIT, 50000, clock cycles per digit slot; must be > BLANK_TICKS
BLANK_TICKS, 500, cycles at slot start with all anodes off; must be >= 1
IDX_W, $clog2(NUM_DIGITS), width of the digit index

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  1 = scan; 0 = hold counters, all anodes off
digits_in  in  4*NUM_DIGITS  packed nibbles; digit k = bits [4k+3:4k]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_mask  in  NUM_DIGITS  1 = digit k never lit
anodo  out  NUM_DIGITS  active-low one-hot anode enables
segmentos  out  7  active-low segments {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
digit_idx  out  IDX_W  index of the current slot
frame_pulse  out  1  one-cycle high at start of slot 0

Behaviour:
- Reset (async assert, sync release): cnt=0, idx=0, latched nibble=0, latched dp=0, latched blank=1. Outputs: anodo all 1, segmentos 7'h7F, dp 1, digit_idx 0, frame_pulse 0.
- Prescaler cnt counts 0..TICKS_PER_DIGIT-1 while enable=1. At cnt==TICKS_PER_DIGIT-1: cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0. This holds for non-power-of-two NUM_DIGITS.
- Slot latch: on a cycle with cnt==0 and enable=1, latch digits_in[idx], dp_in[idx] and blank_mask[idx]. Input changes mid-slot are ignored until the next slot.
- Output register, one cycle latency from (cnt, idx, latch):
  - lit = enable && cnt >= BLANK_TICKS && !latched_blank.
  - lit=1: anodo = ~(1<<idx); segmentos = decode(latched nibble); dp = ~latched_dp.
  - lit=0: anodo all 1; segmentos 7'h7F; dp 1.
- The first BLANK_TICKS cycles of every slot are dark. This includes the latch cycle, so stale data is never shown.
- Decode: full hex, 0-9 and A-F. Examples: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
- digit_idx is the registered idx, aligned with anodo.
- frame_pulse is registered high for one cycle when idx==0 and cnt==0 and enable=1. It is aligned with the first dark cycle of slot 0.
- enable=0: cnt and idx hold; the latch holds; outputs go dark on the next cycle. When enable returns to 1, counting resumes from the held cnt with no re-latch unless cnt==0.
- Simultaneous cases:
  - reset_n low overrides everything, at any point mid-slot.
  - blank_mask changing mid-slot takes effect at the next slot latch.
- Never more than one anode low; no cycle with two anodes low across a slot boundary.

Decomposition:
- Shared package: 7-segment encodings SEG_0..SEG_F, SEG_OFF=7'h7F, and an anode-off constant helper.
- One natural sub-module: seg7_decoder, combinational 4-bit nibble -> 7-bit active-low segments, reusable by other display blocks.

Test Plan:
All scenarios use NUM_DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2.
- Reset and scan: digits_in=16'h4321, dp_in=0, blank_mask=0, enable=1, release reset. Each 8-cycle slot shows 2 dark cycles then 6 lit cycles. anodo sequence 1110,1101,1011,0111 with segmentos for 1,2,3,4. frame_pulse every 32 cycles.
- Blanking: blank_mask=4'b0100. Slot 2 stays fully dark (anodo 1111, segmentos 7F) for all 8 cycles; other slots are unaffected.
- Mid-slot change: change digits_in from 16'h0000 to 16'h8888 at cnt=4 of slot 1. Slot 1 keeps showing 0 (7'b1000000); slot 2 shows 8 (7'h00).
- Enable hold: deassert enable for 10 cycles at cnt=5 of slot 3. Outputs go dark next cycle; digit_idx stays 3. On re-enable, the slot completes its remaining cycles and then wraps to 0 with frame_pulse.
- Async reset mid-slot: pull reset_n low at cnt=4 of slot 2. anodo goes to 1111 and segmentos to 7F immediately, without waiting for a clock edge; the scan restarts at idx 0 after release.
- NUM_DIGITS=3 build: idx wraps 2 -> 0, anodo cycles 110,101,011, and frame_pulse occurs every 24 cycles.
